// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loader : boot-time byte-stream loader for the instruction memory       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module imem_loader #(
  parameter int ADDR_WIDTH = 14,
  parameter int BASE_WORD  = 0,
  parameter int MAX_WORDS  = 16384
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]           mem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           word_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [31:0] c_base_word = 32'(BASE_WORD);
  localparam logic [31:0] c_max_words = 32'(MAX_WORDS);

  state_t                r_state;
  logic [1:0]            r_bcnt;
  logic [31:0]           r_shift;
  logic [31:0]           r_len;
  logic [31:0]           r_wcnt;
  logic [7:0]            r_csum;
  logic                  r_ready;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [31:0]           r_wdata;
  logic                  r_hold;
  logic                  r_done;
  logic                  r_err;

  logic                  w_xfer;
  logic                  w_start;
  logic [31:0]           w_word;

  assign w_xfer  = byte_valid & r_ready;
  assign w_start = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
  // Little-endian assembly: each new byte enters at the top and shifts down.
  assign w_word  = {byte_data, r_shift[31:8]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_bcnt  <= 2'd0;
      r_shift <= 32'd0;
      r_len   <= 32'd0;
      r_wcnt  <= 32'd0;
      r_csum  <= 8'd0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= 32'd0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_state <= S_LEN;
        r_bcnt  <= 2'd0;
        r_shift <= 32'd0;
        r_len   <= 32'd0;
        r_wcnt  <= 32'd0;
        r_csum  <= 8'd0;
        r_ready <= 1'b1;
        r_hold  <= 1'b1;
        r_done  <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        case (r_state)
          S_LEN: begin
            if (w_xfer) begin
              r_shift <= w_word;
              r_bcnt  <= r_bcnt + 2'd1;
              if (r_bcnt == 2'd3) begin
                r_len <= w_word;
                if (w_word > c_max_words) begin
                  r_state <= S_ERR;
                  r_ready <= 1'b0;
                  r_err   <= 1'b1;
                end else if (w_word == 32'd0) begin
                  r_state <= S_CHK;
                end else begin
                  r_state <= S_DATA;
                end
              end
            end
          end
          S_DATA: begin
            if (w_xfer) begin
              r_shift <= w_word;
              r_csum  <= r_csum ^ byte_data;
              r_bcnt  <= r_bcnt + 2'd1;
              if (r_bcnt == 2'd3) begin
                r_we    <= 1'b1;
                r_waddr <= ADDR_WIDTH'(c_base_word + r_wcnt);
                r_wdata <= w_word;
                r_wcnt  <= r_wcnt + 32'd1;
                if (r_wcnt + 32'd1 == r_len) r_state <= S_CHK;
              end
            end
          end
          S_CHK: begin
            if (w_xfer) begin
              r_ready <= 1'b0;
              if (byte_data == r_csum) begin
                r_state <= S_DONE;
                r_hold  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_ready = r_ready;
  assign mem_we     = r_we;
  assign mem_waddr  = r_waddr;
  assign mem_wdata  = r_wdata;
  // Hold must be back on the very cycle a reload is requested from DONE.
  assign core_hold  = r_hold | (start & (r_state == S_DONE));
  assign done       = r_done;
  assign err        = r_err;
  assign word_count = r_wcnt;

endmodule
`default_nettype wire
